// File: rtl/tdm_frame_collector.sv
// TDM serial audio frame collector: oversamples bclk/fs/sdata, deserializes NUM_CH slots
// and publishes them as sign-extended, left-shifted DSP words with a one-cycle start pulse.
module tdm_frame_collector #(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned SLOT_BITS   = 32,
  parameter int unsigned SAMPLE_BITS = 24,
  parameter int unsigned DATA_WIDTH  = 36,
  parameter int unsigned SHIFT       = 10
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  bclk_i,
  input  logic                  fs_i,
  input  logic                  sdata_i,
  output logic [DATA_WIDTH-1:0] samples_o [NUM_CH],
  output logic                  start_o,
  output logic                  frame_err_o,
  output logic                  sync_lost_o,
  output logic                  locked_o
);

  localparam int unsigned FRAME_BITS = NUM_CH * SLOT_BITS;
  localparam int unsigned LOST_BITS  = FRAME_BITS + SLOT_BITS;
  localparam int unsigned LAST_BIT   = (NUM_CH - 1) * SLOT_BITS + SAMPLE_BITS - 1;
  localparam int unsigned CNT_W      = $clog2(LOST_BITS + 1);
  localparam int unsigned EXT_W      = DATA_WIDTH - SAMPLE_BITS;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic                   bclk_s1_q, bclk_s2_q, bclk_h_q;
  logic                   fs_s1_q, fs_s2_q;
  logic                   sd_s1_q, sd_s2_q;
  logic                   fs_prev_q, fs_prev_d;
  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SAMPLE_BITS-1:0] acc_q [NUM_CH];
  logic [SAMPLE_BITS-1:0] acc_d [NUM_CH];
  logic                   pub_q, pub_d;
  logic                   ferr_q, ferr_d;
  logic                   lost_q, lost_d;
  logic                   locked_q, locked_d;
  logic                   start_q;
  logic [DATA_WIDTH-1:0]  samples_q [NUM_CH];

  logic                   tick, fs_edge;
  logic                   cap_en;
  logic [CNT_W-1:0]       cap_idx;
  logic [31:0]            pos_slot, pos_bit;

  assign tick    = bclk_s2_q & ~bclk_h_q;
  assign fs_edge = fs_s2_q & ~fs_prev_q;

  // Framing FSM: decides capture position, publish, error and lock events per tick.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    fs_prev_d = fs_prev_q;
    pub_d     = 1'b0;
    ferr_d    = 1'b0;
    lost_d    = 1'b0;
    locked_d  = locked_q;
    cap_en    = 1'b0;
    cap_idx   = cnt_q;
    pos_slot  = '0;
    pos_bit   = '0;
    if (tick) begin
      fs_prev_d = fs_s2_q;
      case (state_q)
        ST_IDLE: begin
          if (fs_edge) begin
            state_d = ST_RUN;
            cap_en  = 1'b1;
            cap_idx = '0;
          end
        end
        ST_RUN: begin
          cap_en = 1'b1;
          if (fs_edge) begin
            ferr_d   = 1'b1;
            locked_d = 1'b0;
            cap_idx  = '0;
          end else if (cnt_q == CNT_W'(LAST_BIT)) begin
            state_d = ST_WAIT;
            pub_d   = 1'b1;
          end
        end
        ST_WAIT: begin
          if (fs_edge) begin
            state_d = ST_RUN;
            cap_en  = 1'b1;
            cap_idx = '0;
            if (cnt_q == CNT_W'(FRAME_BITS)) begin
              locked_d = 1'b1;
            end else begin
              ferr_d   = 1'b1;
              locked_d = 1'b0;
            end
          end else if (cnt_q >= CNT_W'(LOST_BITS)) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            lost_d   = 1'b1;
            locked_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
      if (cap_en) begin
        cnt_d    = cap_idx + CNT_W'(1);
        pos_slot = 32'(cap_idx) / SLOT_BITS;
        pos_bit  = 32'(cap_idx) % SLOT_BITS;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          if (pos_slot == c && pos_bit < SAMPLE_BITS) begin
            acc_d[c] = {acc_q[c][SAMPLE_BITS-2:0], sd_s2_q};
          end
        end
      end
    end
  end

  // Synchronizers, FSM state and event flags.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      bclk_s1_q <= 1'b0;
      bclk_s2_q <= 1'b0;
      bclk_h_q  <= 1'b0;
      fs_s1_q   <= 1'b0;
      fs_s2_q   <= 1'b0;
      sd_s1_q   <= 1'b0;
      sd_s2_q   <= 1'b0;
      fs_prev_q <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pub_q     <= 1'b0;
      ferr_q    <= 1'b0;
      lost_q    <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      bclk_s1_q <= bclk_i;
      bclk_s2_q <= bclk_s1_q;
      bclk_h_q  <= bclk_s2_q;
      fs_s1_q   <= fs_i;
      fs_s2_q   <= fs_s1_q;
      sd_s1_q   <= sdata_i;
      sd_s2_q   <= sd_s1_q;
      fs_prev_q <= fs_prev_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pub_q     <= pub_d;
      ferr_q    <= ferr_d;
      lost_q    <= lost_d;
      locked_q  <= locked_d;
    end
  end

  // Slot accumulators and the published frame; publish lags the final capture by one edge.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      start_q <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        acc_q[c]     <= '0;
        samples_q[c] <= '0;
      end
    end else begin
      start_q <= pub_q;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= acc_d[c];
        if (pub_q) begin
          samples_q[c] <= {{EXT_W{acc_q[c][SAMPLE_BITS-1]}}, acc_q[c]} << SHIFT;
        end
      end
    end
  end

  assign samples_o   = samples_q;
  assign start_o     = start_q;
  assign frame_err_o = ferr_q;
  assign sync_lost_o = lost_q;
  assign locked_o    = locked_q;

endmodule

// File: doc/tdm_frame_collector.md
Name: tdm_frame_collector

Overview:
- Upstream neighbour of the DSP core: receives an 8-channel TDM serial audio stream (bclk, fs, sdata) from the ADC, oversampled in the system clock domain.
- Deserializes one 24-bit two's-complement sample per slot and converts each to the core's 36-bit fixed-point word.
- Presents all channels as a parallel frame, together with a one-cycle start pulse that kicks the core's per-sample program.
- Flags framing errors and reports lock status.

Parameters:
- NUM_CH, 8, channels (slots) per frame.
- SLOT_BITS, 32, bclk periods per slot.
- SAMPLE_BITS, 24, valid MSB-first bits at the head of each slot; must be ≤ SLOT_BITS.
- DATA_WIDTH, 36, output word width.
- SHIFT, 10, left shift applied after sign extension; SAMPLE_BITS+SHIFT must be ≤ DATA_WIDTH.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-low reset; reset=0 at a clk edge resets the block.
- bclk  input  1  TDM bit clock, asynchronous to clk.
- fs  input  1  TDM frame sync, asynchronous.
- sdata  input  1  TDM serial data, asynchronous.
- samples[NUM_CH]  output  DATA_WIDTH each  parallel frame; feeds the core's inputs.
- start  output  1  one-cycle pulse when samples update; feeds the core's start.
- frame_err  output  1  one-cycle pulse: fs arrived early.
- sync_lost  output  1  one-cycle pulse: fs missing.
- locked  output  1  stream is framing correctly.

Behaviour:
- Reset (reset=0 at a clk edge): samples all 0, start=0, frame_err=0, sync_lost=0, locked=0, state IDLE, bit counter 0, synchronizers cleared.
- Input conditioning: bclk, fs and sdata each pass through 2 flops plus a history flop.
- A bclk rising edge ("tick") is flagged when the sync output is 1 and the history flop is 0.
- fs and sdata are read from the same sync stage as bclk, so all three stay aligned.
- Requirement on the stream: bclk high and low phases are each ≥3 clk periods.
- On a tick, fs_edge = fs_sync AND NOT fs_prev. fs_prev updates only on ticks.
- Frame start: the tick with fs_edge carries bit 0 (MSB) of slot 0, i.e. zero bit delay.
- Bit counter b runs 0..NUM_CH*SLOT_BITS-1. Slot = b / SLOT_BITS, bit-in-slot = b % SLOT_BITS.
- Bits with bit-in-slot < SAMPLE_BITS are shifted MSB-first into that slot's accumulator; all other bits are ignored.
- Conversion: out = sign_extend(sample, DATA_WIDTH) << SHIFT. Low SHIFT bits are 0; no saturation is needed.
- States:
  - IDLE: ignore data; on fs_edge go to RUN with b=0 and capture the bit.
  - RUN: capture per tick; b increments each tick.
    - On the tick capturing the last sample bit of slot NUM_CH-1, go to WAIT.
  - WAIT: count ticks without capturing.
    - fs_edge exactly when b == NUM_CH*SLOT_BITS: set locked=1, go to RUN with b=0, capture the bit.
    - fs_edge earlier: treated as an early fs (see below).
- Publish:
  - On the clk edge after the final-bit capture, all samples update simultaneously and start=1 for exactly one cycle.
  - Pin-to-start latency: if bclk is first sampled 1 at edge N for the final bit, start is high after edge N+3.
  - samples hold until the next publish.
- Early fs: fs_edge in RUN, or in WAIT with b < NUM_CH*SLOT_BITS.
  - Pulse frame_err and clear locked.
  - Discard the partial frame; no publish and samples unchanged.
  - Restart RUN at b=0 with this tick as bit 0.
- Missing fs: in WAIT, if b reaches NUM_CH*SLOT_BITS+SLOT_BITS without fs_edge:
  - Pulse sync_lost, clear locked, go to IDLE.
- Simultaneous events: if fs_edge coincides with the missing-fs limit, fs_edge wins and is handled as a normal/early fs; no sync_lost.
- Reset mid-frame discards everything. After reset=1, the first publish requires a full frame starting at a fresh fs_edge.

Test Plan:
- Reset, then 2 clean frames with slot i = 24'h000001*(i+1) -> start pulses once per frame, one cycle wide; samples[i] = (i+1)<<10, e.g. samples[7] = 36'h000002000; locked=1 from the second fs onward.
- Slot 0 = 24'h800000, slot 1 = 24'hFFFFFF, slot 2 = 24'h7FFFFF -> samples[0] = 36'hE00000000, samples[1] = 36'hFFFFFFC00, samples[2] = 36'h1FFFFFC00.
- fs reasserted at bit 100 of a frame -> frame_err pulses once, locked=0, no start, old samples retained; the following complete frame publishes correct data.
- fs withheld after a complete frame -> sync_lost pulses exactly 288 ticks after the last fs edge; locked=0; state IDLE, with no start until a new fs_edge plus a full frame.
- reset=0 for 1 cycle mid-slot 5 -> next edge: all samples 0, locked=0; no start until a full fresh frame completes.
- Latency: measure clk edges from the first sampling of bclk=1 on the last sample bit (slot 7, bit 23) to start=1 -> exactly 3.
